// File: rtl/tcdm_bank_responder_pkg.sv
// Shared types and constants for the TCDM bank responder: payload layout,
// AMO opcodes and the default response buffer depth.
package tcdm_bank_responder_pkg;

  localparam int unsigned DataWidth            = 32;
  localparam int unsigned BeWidth              = DataWidth / 8;
  localparam int unsigned TCDMAddrMemWidth     = 10;
  localparam int unsigned MetaIdWidth          = 5;
  localparam int unsigned CoreIdWidth          = 4;
  localparam int unsigned TileGroupIdWidth     = 4;
  localparam int unsigned RespFifoDepthDefault = 2;

  typedef logic [DataWidth-1:0]        data_t;
  typedef logic [BeWidth-1:0]          strb_t;
  typedef logic [TCDMAddrMemWidth-1:0] bank_addr_t;
  typedef logic [MetaIdWidth-1:0]      meta_id_t;
  typedef logic [CoreIdWidth-1:0]      core_id_t;
  typedef logic [TileGroupIdWidth-1:0] tile_group_id_t;
  typedef logic [3:0]                  amo_t;

  localparam amo_t AmoNone = 4'd0;
  localparam amo_t AmoSwap = 4'd1;
  localparam amo_t AmoAdd  = 4'd2;
  localparam amo_t AmoAnd  = 4'd3;
  localparam amo_t AmoOr   = 4'd4;
  localparam amo_t AmoXor  = 4'd5;
  localparam amo_t AmoMax  = 4'd6;
  localparam amo_t AmoMaxu = 4'd7;
  localparam amo_t AmoMin  = 4'd8;
  localparam amo_t AmoMinu = 4'd9;

  typedef struct packed {
    meta_id_t meta_id;
    core_id_t core_id;
    amo_t     amo;
    data_t    data;
  } tcdm_payload_t;

  typedef struct packed {
    tile_group_id_t ini_addr;
    tcdm_payload_t  payload;
  } resp_t;

  typedef enum logic {
    StIdle  = 1'b0,
    StAmoWb = 1'b1
  } state_e;

  // Codes above the AMO range (reserved/LR/SC) are deliberately not AMOs.
  function automatic logic is_amo(amo_t code);
    return (code >= AmoSwap) && (code <= AmoMinu);
  endfunction

endpackage

// File: rtl/tcdm_bank_responder_if.sv
// Request, response and SRAM-side signals of one TCDM bank responder,
// named from the responder's point of view.
interface tcdm_bank_responder_if
  import tcdm_bank_responder_pkg::*;
#(
  parameter int unsigned BankAddrWidth = TCDMAddrMemWidth
);

  logic                     in_valid_i;
  logic                     in_ready_o;
  tcdm_payload_t            in_wdata_i;
  logic                     in_wen_i;
  strb_t                    in_be_i;
  logic [BankAddrWidth-1:0] in_addr_i;
  tile_group_id_t           in_ini_addr_i;

  logic                     out_valid_o;
  logic                     out_ready_i;
  tcdm_payload_t            out_rdata_o;
  tile_group_id_t           out_ini_addr_o;

  logic                     mem_req_o;
  logic                     mem_we_o;
  logic [BankAddrWidth-1:0] mem_addr_o;
  data_t                    mem_wdata_o;
  strb_t                    mem_be_o;
  data_t                    mem_rdata_i;

  modport slave (
    input  in_valid_i, in_wdata_i, in_wen_i, in_be_i, in_addr_i, in_ini_addr_i,
    output in_ready_o,
    output out_valid_o, out_rdata_o, out_ini_addr_o,
    input  out_ready_i,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
    input  mem_rdata_i
  );

  modport master (
    output in_valid_i, in_wdata_i, in_wen_i, in_be_i, in_addr_i, in_ini_addr_i,
    input  in_ready_o,
    input  out_valid_o, out_rdata_o, out_ini_addr_o,
    output out_ready_i,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
    output mem_rdata_i
  );

endinterface

// File: rtl/tcdm_resp_fifo.sv
// Fall-through response FIFO: a push into an empty FIFO is visible on the
// output in the same cycle and is only stored if it is not popped at once.
module tcdm_resp_fifo #(
  parameter int unsigned Depth = 2,
  parameter int unsigned DataW = 32,
  parameter int unsigned CntW  = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [DataW-1:0] data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [DataW-1:0] data_o,
  output logic [CntW-1:0]  count_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [DataW-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_q, rd_q;
  logic [CntW-1:0]  cnt_q;
  logic             empty, store, deq;

  function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign empty   = (cnt_q == '0);
  assign store   = push_i && !(empty && pop_i);
  assign deq     = pop_i && !empty;
  assign valid_o = push_i || !empty;
  assign data_o  = empty ? data_i : mem_q[rd_q];
  assign count_o = cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (store) wr_q <= ptr_inc(wr_q);
      if (deq)   rd_q <= ptr_inc(rd_q);
      cnt_q <= cnt_q + CntW'(store) - CntW'(deq);
    end
  end

  always_ff @(posedge clk_i) begin
    if (store) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/tcdm_bank_responder.sv
// TCDM bank responder: serves reads, writes and AMOs on one single-port SRAM
// bank and returns credit-limited responses echoing the routing fields.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   StIdle  | accept requests; reads/AMOs need a response credit
//   StAmoWb | write back op(old, operand); old value goes to the response
module tcdm_bank_responder
  import tcdm_bank_responder_pkg::*;
#(
  parameter int unsigned RespFifoDepth = RespFifoDepthDefault,
  parameter int unsigned BankAddrWidth = TCDMAddrMemWidth
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  tcdm_bank_responder_if.slave  bus
);

  localparam int unsigned CntW = $clog2(RespFifoDepth + 1);

  state_e                   state_q, state_d;
  logic                     pend_q, pend_d;
  meta_id_t                 meta_id_q, meta_id_d;
  core_id_t                 core_id_q, core_id_d;
  amo_t                     amo_q, amo_d;
  tile_group_id_t           ini_q, ini_d;
  logic [BankAddrWidth-1:0] amo_addr_q, amo_addr_d;
  data_t                    operand_q, operand_d;

  tcdm_payload_t   req;
  logic            req_amo, req_plain_wr;
  logic            in_ready, accept, credit_ok;
  logic            fifo_push, fifo_pop, fifo_valid;
  resp_t           fifo_wdata, fifo_rdata;
  logic [CntW-1:0] fifo_count;

  function automatic data_t amo_alu(amo_t op, data_t old_v, data_t opd);
    data_t res;
    case (op)
      AmoSwap: res = opd;
      AmoAdd:  res = old_v + opd;
      AmoAnd:  res = old_v & opd;
      AmoOr:   res = old_v | opd;
      AmoXor:  res = old_v ^ opd;
      AmoMax:  res = ($signed(old_v) > $signed(opd)) ? old_v : opd;
      AmoMaxu: res = (old_v > opd) ? old_v : opd;
      AmoMin:  res = ($signed(old_v) < $signed(opd)) ? old_v : opd;
      AmoMinu: res = (old_v < opd) ? old_v : opd;
      default: res = old_v;
    endcase
    return res;
  endfunction

  assign req          = bus.in_wdata_i;
  assign req_amo      = is_amo(req.amo);
  assign req_plain_wr = bus.in_wen_i && (req.amo == AmoNone);

  // The SRAM data of the access made last cycle completes the response.
  assign fifo_push  = pend_q && !rst_i;
  assign fifo_pop   = fifo_valid && bus.out_ready_i && !rst_i;
  assign fifo_wdata = '{ini_addr: ini_q,
                        payload: '{meta_id: meta_id_q, core_id: core_id_q,
                                   amo: amo_q, data: bus.mem_rdata_i}};

  tcdm_resp_fifo #(
    .Depth (RespFifoDepth),
    .DataW ($bits(resp_t))
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push),
    .data_i  (fifo_wdata),
    .pop_i   (fifo_pop),
    .valid_o (fifo_valid),
    .data_o  (fifo_rdata),
    .count_o (fifo_count)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      pend_q     <= 1'b0;
      meta_id_q  <= '0;
      core_id_q  <= '0;
      amo_q      <= '0;
      ini_q      <= '0;
      amo_addr_q <= '0;
      operand_q  <= '0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      meta_id_q  <= meta_id_d;
      core_id_q  <= core_id_d;
      amo_q      <= amo_d;
      ini_q      <= ini_d;
      amo_addr_q <= amo_addr_d;
      operand_q  <= operand_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pend_d     = 1'b0;
    meta_id_d  = meta_id_q;
    core_id_d  = core_id_q;
    amo_d      = amo_q;
    ini_d      = ini_q;
    amo_addr_d = amo_addr_q;
    operand_d  = operand_q;
    case (state_q)
      StIdle: begin
        if (accept && !req_plain_wr) begin
          pend_d     = 1'b1;
          meta_id_d  = req.meta_id;
          core_id_d  = req.core_id;
          amo_d      = req.amo;
          ini_d      = bus.in_ini_addr_i;
          amo_addr_d = bus.in_addr_i;
          operand_d  = req.data;
          if (req_amo) state_d = StAmoWb;
        end
      end
      StAmoWb: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    // A pop this cycle releases its credit immediately.
    credit_ok = (int'(fifo_count) + int'(pend_q) - int'(fifo_pop)) < int'(RespFifoDepth);
    in_ready  = !rst_i && (state_q == StIdle) && (credit_ok || req_plain_wr);
    accept    = bus.in_valid_i && in_ready;

    bus.in_ready_o  = in_ready;
    bus.mem_req_o   = 1'b0;
    bus.mem_we_o    = 1'b0;
    bus.mem_addr_o  = '0;
    bus.mem_wdata_o = '0;
    bus.mem_be_o    = '0;
    if (accept) begin
      bus.mem_req_o  = 1'b1;
      bus.mem_we_o   = req_plain_wr;
      bus.mem_addr_o = bus.in_addr_i;
      if (req_plain_wr) begin
        bus.mem_wdata_o = req.data;
        bus.mem_be_o    = bus.in_be_i;
      end
    end
    if (!rst_i && (state_q == StAmoWb)) begin
      bus.mem_req_o   = 1'b1;
      bus.mem_we_o    = 1'b1;
      bus.mem_addr_o  = amo_addr_q;
      bus.mem_wdata_o = amo_alu(amo_q, bus.mem_rdata_i, operand_q);
      bus.mem_be_o    = '1;
    end

    bus.out_valid_o    = fifo_valid && !rst_i;
    bus.out_rdata_o    = bus.out_valid_o ? fifo_rdata.payload  : '0;
    bus.out_ini_addr_o = bus.out_valid_o ? fifo_rdata.ini_addr : '0;
  end

endmodule

// File: tb/tb_tcdm_bank_responder.sv
// Bench for tcdm_bank_responder: directed requests push expected responses
// into a queue that a negedge monitor drains against the DUT output.
module tb_tcdm_bank_responder;
  import tcdm_bank_responder_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tcdm_bank_responder_if bus ();

  tcdm_bank_responder dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int    checks   = 0;
  int    failures = 0;
  int    tag      = 0;
  resp_t exp_q[$];
  data_t sram [1024];

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic data_t merge(data_t old_v, data_t new_v, strb_t be);
    data_t r = old_v;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

  // SRAM model: write on strobe, read data registered one cycle later.
  always @(posedge clk) begin
    if (bus.mem_req_o) begin
      if (bus.mem_we_o)
        sram[bus.mem_addr_o] <= merge(sram[bus.mem_addr_o], bus.mem_wdata_o, bus.mem_be_o);
      else
        bus.mem_rdata_i <= sram[bus.mem_addr_o];
    end
  end

  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic [48:0] prev_data  = '0;

  always @(negedge clk) begin
    resp_t e;
    if (!rst && prev_valid && !prev_ready) begin
      check("hold_valid", 64'(bus.out_valid_o), 64'(1));
      check("hold_data", 64'({bus.out_ini_addr_o, bus.out_rdata_o}), 64'(prev_data));
    end
    check("fifo_no_overflow", 64'(int'(dut.u_fifo.count_o) <= 2), 64'(1));
    if (bus.out_valid_o && bus.out_ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_resp actual=0x%0h required=none at %0t",
                 {bus.out_ini_addr_o, bus.out_rdata_o}, $time);
      end else begin
        e = exp_q.pop_front();
        check("resp", 64'({bus.out_ini_addr_o, bus.out_rdata_o}), 64'(e));
      end
    end
    prev_valid = bus.out_valid_o;
    prev_ready = bus.out_ready_i;
    prev_data  = {bus.out_ini_addr_o, bus.out_rdata_o};
  end

  task automatic drive(logic wen, amo_t amo, logic [9:0] a, data_t d, strb_t be,
                       meta_id_t meta, core_id_t core, tile_group_id_t ini);
    bus.in_valid_i    = 1'b1;
    bus.in_wen_i      = wen;
    bus.in_wdata_i    = '{meta_id: meta, core_id: core, amo: amo, data: d};
    bus.in_be_i       = be;
    bus.in_addr_i     = a;
    bus.in_ini_addr_i = ini;
  endtask

  task automatic send(logic wen, amo_t amo, logic [9:0] a, data_t d, strb_t be,
                      logic want, data_t expd);
    bit done = 1'b0;
    meta_id_t meta = 5'(tag);
    core_id_t core = 4'(tag);
    tile_group_id_t ini = 4'(tag ^ 5);
    tag++;
    drive(wen, amo, a, d, be, meta, core, ini);
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (bus.in_ready_o) begin
        done = 1'b1;
        if (want)
          exp_q.push_back('{ini_addr: ini,
                            payload: '{meta_id: meta, core_id: core, amo: amo, data: expd}});
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=not_accepted required=accepted addr=0x%0h", a);
    end
    bus.in_valid_i = 1'b0;
  endtask

  task automatic wr(logic [9:0] a, data_t d, strb_t be);
    send(1'b1, AmoNone, a, d, be, 1'b0, '0);
  endtask

  task automatic rq(amo_t op, logic [9:0] a, data_t d, data_t expd);
    send(1'b0, op, a, d, 4'hF, 1'b1, expd);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain_empty", 64'(exp_q.size()), 64'(0));
  endtask

  logic [9:0] t5_addr [4] = '{10'h010, 10'h020, 10'h030, 10'h040};
  data_t      t5_exp  [4] = '{32'hDEADAAAA, 32'h00000003, 32'h00000001, 32'h80000000};

  initial begin
    int acc;
    bus.in_valid_i    = 1'b0;
    bus.in_wen_i      = 1'b0;
    bus.in_wdata_i    = '0;
    bus.in_be_i       = '0;
    bus.in_addr_i     = '0;
    bus.in_ini_addr_i = '0;
    bus.out_ready_i   = 1'b1;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready_o), 64'(0));
    check("rst_out_valid", 64'(bus.out_valid_o), 64'(0));
    check("rst_mem_req", 64'(bus.mem_req_o), 64'(0));
    check("rst_mem_we", 64'(bus.mem_we_o), 64'(0));
    check("rst_out_rdata", 64'(bus.out_rdata_o), 64'(0));
    check("rst_mem_addr", 64'(bus.mem_addr_o), 64'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 64'(bus.in_ready_o), 64'(1));
    @(posedge clk);
    #1;

    // write then read with single-cycle bypass latency
    wr(10'h010, 32'hDEADBEEF, 4'hF);
    rq(AmoNone, 10'h010, '0, 32'hDEADBEEF);
    @(negedge clk);
    check("rd_lat_valid", 64'(bus.out_valid_o), 64'(1));
    check("rd_lat_data", 64'(bus.out_rdata_o.data), 64'(32'hDEADBEEF));
    @(posedge clk);
    #1;

    wr(10'h010, 32'h0000AAAA, 4'b0011);
    rq(AmoNone, 10'h010, '0, 32'hDEADAAAA);

    // AMOADD wraps; write-back cycle blocks exactly one cycle
    wr(10'h020, 32'hFFFFFFFE, 4'hF);
    send(1'b0, AmoAdd, 10'h020, 32'h5, 4'h3, 1'b1, 32'hFFFFFFFE);
    fork
      rq(AmoNone, 10'h020, '0, 32'h00000003);
      begin
        @(negedge clk);
        check("amo_wb_ready_low", 64'(bus.in_ready_o), 64'(0));
        check("amo_wb_we", 64'(bus.mem_we_o), 64'(1));
        check("amo_wb_addr", 64'(bus.mem_addr_o), 64'(10'h020));
        check("amo_wb_wdata", 64'(bus.mem_wdata_o), 64'(32'h00000003));
        check("amo_wb_be", 64'(bus.mem_be_o), 64'(4'hF));
        @(negedge clk);
        check("amo_after_ready", 64'(bus.in_ready_o), 64'(1));
      end
    join

    wr(10'h030, 32'h80000000, 4'hF);
    rq(AmoMax, 10'h030, 32'h00000001, 32'h80000000);
    rq(AmoNone, 10'h030, '0, 32'h00000001);
    wr(10'h040, 32'h80000000, 4'hF);
    rq(AmoMaxu, 10'h040, 32'h00000001, 32'h80000000);
    rq(AmoNone, 10'h040, '0, 32'h80000000);
    wr(10'h050, 32'h00000010, 4'hF);
    rq(AmoMin,  10'h050, 32'hFFFFFFFF, 32'h00000010);
    rq(AmoXor,  10'h050, 32'hFFFF0000, 32'hFFFFFFFF);
    rq(AmoMinu, 10'h050, 32'h00001000, 32'h0000FFFF);
    rq(AmoSwap, 10'h050, 32'h12345678, 32'h00001000);
    rq(AmoAnd,  10'h050, 32'h0F0F0F0F, 32'h12345678);
    rq(AmoOr,   10'h050, 32'h80000001, 32'h02040608);
    send(1'b1, 4'd12, 10'h050, 32'hFFFFFFFF, 4'hF, 1'b1, 32'h82040609);
    rq(AmoNone, 10'h050, '0, 32'h82040609);
    drain();

    // backpressure: only two reads fit the response credits
    bus.out_ready_i = 1'b0;
    acc = 0;
    drive(1'b0, AmoNone, t5_addr[0], '0, 4'hF, 5'(20), 4'd0, 4'd1);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.in_valid_i && bus.in_ready_o) begin
        exp_q.push_back('{ini_addr: 4'd1,
                          payload: '{meta_id: 5'(20 + acc), core_id: 4'd0,
                                     amo: AmoNone, data: t5_exp[acc]}});
        acc++;
        @(posedge clk);
        #1;
        drive(1'b0, AmoNone, t5_addr[acc], '0, 4'hF, 5'(20 + acc), 4'd0, 4'd1);
      end else begin
        @(posedge clk);
        #1;
      end
    end
    @(negedge clk);
    check("bp_accepted", 64'(acc), 64'(2));
    check("bp_in_ready", 64'(bus.in_ready_o), 64'(0));
    check("bp_out_valid", 64'(bus.out_valid_o), 64'(1));
    @(posedge clk);
    #1 bus.out_ready_i = 1'b1;
    for (int c = 0; c < 20 && acc < 4; c++) begin
      @(negedge clk);
      if (bus.in_ready_o) begin
        exp_q.push_back('{ini_addr: 4'd1,
                          payload: '{meta_id: 5'(20 + acc), core_id: 4'd0,
                                     amo: AmoNone, data: t5_exp[acc]}});
        acc++;
        @(posedge clk);
        #1;
        if (acc < 4) drive(1'b0, AmoNone, t5_addr[acc], '0, 4'hF, 5'(20 + acc), 4'd0, 4'd1);
      end else begin
        @(posedge clk);
        #1;
      end
    end
    bus.in_valid_i = 1'b0;
    check("bp_all_accepted", 64'(acc), 64'(4));
    drain();

    // reset during AMO write-back drops the write and the response
    wr(10'h060, 32'h00000007, 4'hF);
    send(1'b0, AmoAdd, 10'h060, 32'h1, 4'hF, 1'b0, '0);
    rst = 1'b1;
    @(negedge clk);
    check("rstwb_mem_req", 64'(bus.mem_req_o), 64'(0));
    check("rstwb_mem_we", 64'(bus.mem_we_o), 64'(0));
    check("rstwb_in_ready", 64'(bus.in_ready_o), 64'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rstwb_out_valid", 64'(bus.out_valid_o), 64'(0));
    check("rstwb_fifo_empty", 64'(dut.u_fifo.count_o), 64'(0));
    check("rstwb_in_ready_after", 64'(bus.in_ready_o), 64'(1));
    @(posedge clk);
    #1;
    rq(AmoNone, 10'h060, '0, 32'h00000007);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
